// File: rtl/dlx_pkg.sv
// Shared DLX pipeline definitions: encodings, fetch FSM states and the IF/ID register layout.
package dlx_pkg;

  localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR_DFLT = 32'h4400_0300;

  typedef enum logic {
    StRun,
    StHalted
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register with load/hold/clear; clear (bubble insertion) wins over load.
module ifid_reg
  import dlx_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  logic   clear,
  input  if_id_t din,
  output if_id_t dout
);

  if_id_t data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clear) begin
      data_d = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
    end else if (load) begin
      data_d = din;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q <= '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
    end else begin
      data_q <= data_d;
    end
  end

  assign dout = data_q;

endmodule

// File: rtl/ifetch_stage.sv
// DLX instruction-fetch stage: PC register, RUN/HALTED fetch FSM and the IF/ID register.
module ifetch_stage
  import dlx_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DFLT
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted
);

  logic [31:0]  pc_q, pc_d, pc_plus4;
  fetch_state_e state_q, state_d;
  logic         ifid_load, ifid_clear;
  if_id_t       ifid_in, ifid_out;

  assign pc_plus4 = pc_q + 32'd4;
  assign ifid_in  = '{instr: imem_data, pc4: pc_plus4, valid: 1'b1};

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    ifid_load  = 1'b0;
    ifid_clear = 1'b0;
    if (redirect) begin
      // Also cancels a halt: a trap behind a taken branch is wrong-path.
      pc_d       = {redirect_pc[31:2], 2'b00};
      state_d    = StRun;
      ifid_clear = 1'b1;
    end else if (flush) begin
      ifid_clear = 1'b1;
      if (state_q == StRun && !stall) begin
        pc_d = pc_plus4;
      end
    end else if (stall) begin
      // Hold everything, including ignoring a halt word not yet captured.
    end else if (state_q == StRun) begin
      ifid_load = 1'b1;
      if (imem_data == HALT_INSTR) begin
        state_d = StHalted;
      end else begin
        pc_d = pc_plus4;
      end
    end else begin
      ifid_clear = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      state_q <= StRun;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  ifid_reg u_ifid_reg (
    .clock (clock),
    .reset (reset),
    .load  (ifid_load),
    .clear (ifid_clear),
    .din   (ifid_in),
    .dout  (ifid_out)
  );

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign if_id_instr = ifid_out.instr;
  assign if_id_pc4   = ifid_out.pc4;
  assign if_id_valid = ifid_out.valid;
  assign halted      = (state_q == StHalted);

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage with a queue-based scoreboard of per-edge expectations.
module tb_ifetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr, imem_data;
  logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] pc, if_id_instr, if_id_pc4;
  logic        if_id_valid, halted;

  logic [31:0] imem [64];
  assign imem_data = imem[imem_addr[7:2]];

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
  } expect_t;

  expect_t sb[$];
  int checks = 0;
  int passed = 0;

  ifetch_stage dut (
    .clock       (clock),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic check_all(input expect_t e);
    check({e.tag, ".pc"}, pc, e.pc);
    check({e.tag, ".imem_addr"}, imem_addr, e.pc);
    check({e.tag, ".instr"}, if_id_instr, e.instr);
    check({e.tag, ".pc4"}, if_id_pc4, e.pc4);
    check({e.tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e.valid});
    check({e.tag, ".halted"}, {31'h0, halted}, {31'h0, e.halted});
  endtask

  // Drive one cycle of controls, queue the expected post-edge state, then compare after the edge.
  task automatic step(input string tag, input logic s, input logic f, input logic r,
                      input logic [31:0] rpc, input logic [31:0] e_pc,
                      input logic [31:0] e_instr, input logic [31:0] e_pc4,
                      input logic e_valid, input logic e_halted);
    expect_t e;
    e = '{tag: tag, pc: e_pc, instr: e_instr, pc4: e_pc4, valid: e_valid, halted: e_halted};
    sb.push_back(e);
    stall       = s;
    flush       = f;
    redirect    = r;
    redirect_pc = rpc;
    @(posedge clock);
    #1;
    check_all(sb.pop_front());
  endtask

  initial begin
    expect_t e0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    imem[0]  = 32'h2001_0005;
    imem[1]  = 32'h2002_0007;
    imem[2]  = 32'h2003_0009;
    imem[3]  = 32'h2004_000B;
    imem[4]  = 32'h4400_0300;
    imem[16] = 32'h2005_0001;
    imem[17] = 32'h2006_0002;
    imem[32] = 32'h2007_0003;
    imem[33] = 32'h2008_0004;
    imem[63] = 32'h2009_00FF;

    #1 reset = 1'b0;
    #1;
    e0 = '{tag: "reset", pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, halted: 1'b0};
    check_all(e0);
    #10 reset = 1'b1;

    // Free run and stall
    step("run0",   0, 0, 0, 0, 32'h4,  32'h2001_0005, 32'h4,  1, 0);
    step("run1",   0, 0, 0, 0, 32'h8,  32'h2002_0007, 32'h8,  1, 0);
    step("stall0", 1, 0, 0, 0, 32'h8,  32'h2002_0007, 32'h8,  1, 0);
    step("stall1", 1, 0, 0, 0, 32'h8,  32'h2002_0007, 32'h8,  1, 0);
    step("run2",   0, 0, 0, 0, 32'hC,  32'h2003_0009, 32'hC,  1, 0);

    // Redirect, alignment, flush interactions
    step("redir40", 0, 1, 1, 32'h40, 32'h40, 32'h0, 32'h0, 0, 0);
    step("run40",   0, 0, 0, 0,      32'h44, 32'h2005_0001, 32'h44, 1, 0);
    step("redir43", 0, 0, 1, 32'h43, 32'h40, 32'h0, 32'h0, 0, 0);
    step("run40b",  0, 0, 0, 0,      32'h44, 32'h2005_0001, 32'h44, 1, 0);
    step("stflush", 1, 1, 0, 0,      32'h44, 32'h0, 32'h0, 0, 0);
    step("flush",   0, 1, 0, 0,      32'h48, 32'h0, 32'h0, 0, 0);

    // Halt: a stalled trap word is not captured
    step("redir10",   0, 0, 1, 32'h10, 32'h10, 32'h0, 32'h0, 0, 0);
    step("stallhalt", 1, 0, 0, 0,      32'h10, 32'h0, 32'h0, 0, 0);
    step("halt",      0, 0, 0, 0,      32'h10, 32'h4400_0300, 32'h14, 1, 1);
    for (int i = 0; i < 10; i++) begin
      step("halthold", 0, 0, 0, 0, 32'h10, 32'h0, 32'h0, 0, 1);
    end
    step("haltflush", 0, 1, 0, 0, 32'h10, 32'h0, 32'h0, 0, 1);

    // Wrong-path trap cancelled by a redirect right after capture
    step("redir10b", 0, 0, 1, 32'h10, 32'h10, 32'h0, 32'h0, 0, 0);
    step("halt2",    0, 0, 0, 0,      32'h10, 32'h4400_0300, 32'h14, 1, 1);
    step("redir80",  0, 0, 1, 32'h80, 32'h80, 32'h0, 32'h0, 0, 0);
    step("run80",    0, 0, 0, 0,      32'h84, 32'h2007_0003, 32'h84, 1, 0);
    step("run84",    0, 0, 0, 0,      32'h88, 32'h2008_0004, 32'h88, 1, 0);

    // PC wrap at the top of the address space
    step("redirtop", 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 0);
    step("runwrap",  0, 0, 0, 0,             32'h0, 32'h2009_00FF, 32'h0, 1, 0);

    // Async reset while halted, mid-cycle
    step("redir10c", 0, 0, 1, 32'h10, 32'h10, 32'h0, 32'h0, 0, 0);
    step("halt3",    0, 0, 0, 0,      32'h10, 32'h4400_0300, 32'h14, 1, 1);
    redirect = 1'b0;
    #3 reset = 1'b0;
    #1;
    e0 = '{tag: "asyncrst", pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0, halted: 1'b0};
    check_all(e0);
    #2 reset = 1'b1;
    step("postrst", 0, 0, 0, 0, 32'h4, 32'h2001_0005, 32'h4, 1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
